// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing one LCD byte-write driver between NREQ requesters.
// A grant covers a whole burst; a watchdog force-completes a byte whose dataDone never returns.
module lcd_bus_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 4000
) (
   input  logic                int_osc,
   input  logic                reset,
   input  logic                en,
   input  logic [NREQ-1:0]     req,
   input  logic [8*NREQ-1:0]   reqDataIn,
   input  logic [NREQ-1:0]     reqRS,
   input  logic [NREQ-1:0]     reqRW,
   input  logic [NREQ-1:0]     reqDataReady,
   output logic [NREQ-1:0]     grant,
   output logic [NREQ-1:0]     reqDataDone,
   output logic [7:0]          dataIn,
   output logic                RSin,
   output logic                RWin,
   output logic                dataReady,
   input  logic                dataDone,
   output logic                timeoutErr
);

   localparam int          IDXW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [15:0] LASTCNT = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      BUSY,
      RELEASE
   } arbState_e;

   arbState_e       state;
   logic [IDXW-1:0] owner;
   logic [IDXW-1:0] lastGrant;
   logic [15:0]     timer;

   logic [IDXW-1:0] nextOwner;
   logic            anyReq;
   logic            byteEnd;

   // Round-robin pick: scan downward so the nearest requester after lastGrant is assigned last and wins.
   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      nextOwner = lastGrant;
      anyReq    = |req;
      for (int i = NREQ; i >= 1; i--) begin
         if (req[(int'(lastGrant) + i) % NREQ]) begin
            nextOwner = IDXW'((int'(lastGrant) + i) % NREQ);
         end
      end
   end

   // A byte ends on dataDone or when the watchdog reaches its last count.
   assign byteEnd = dataDone || (timer == LASTCNT);

   always_ff @(posedge int_osc or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         owner       <= '0;
         lastGrant   <= IDXW'(NREQ - 1);
         timer       <= '0;
         grant       <= '0;
         reqDataDone <= '0;
         dataIn      <= '0;
         RSin        <= 1'b0;
         RWin        <= 1'b0;
         dataReady   <= 1'b0;
         timeoutErr  <= 1'b0;
      end else if (en) begin
         // NOTE: clocked state uses non-blocking assignments only, so every register sees pre-edge values.
         reqDataDone <= '0;
         timeoutErr  <= 1'b0;
         case (state)
            IDLE: begin
               if (anyReq) begin
                  owner <= nextOwner;
                  grant <= {{(NREQ-1){1'b0}}, 1'b1} << nextOwner;
                  state <= GRANT;
               end
            end

            GRANT: begin
               dataReady <= 1'b0;
               if (reqDataReady[owner]) begin
                  dataIn    <= reqDataIn[8*owner +: 8];
                  RSin      <= reqRS[owner];
                  RWin      <= reqRW[owner];
                  dataReady <= 1'b1;
                  timer     <= '0;
                  state     <= BUSY;
               end else if (!req[owner]) begin
                  grant     <= '0;
                  dataIn    <= '0;
                  RSin      <= 1'b0;
                  RWin      <= 1'b0;
                  lastGrant <= owner;
                  state     <= RELEASE;
               end
            end

            BUSY: begin
               // Driver outputs hold here; req drops are only seen back in GRANT.
               if (byteEnd) begin
                  dataReady   <= 1'b0;
                  reqDataDone <= grant;
                  timeoutErr  <= !dataDone;
                  state       <= GRANT;
               end else begin
                  timer <= timer + 16'd1;
               end
            end

            RELEASE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: burst transfer, round-robin order, drop during a byte,
// async reset, watchdog expiry and clock-enable freeze, with a requester and a driver model.
module tb_lcd_bus_arbiter;

   localparam int NREQ    = 2;
   localparam int TIMEOUT = 20;

   logic              int_osc;
   logic              reset;
   logic              en;
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] reqDataIn;
   logic [NREQ-1:0]   reqRS;
   logic [NREQ-1:0]   reqRW;
   logic [NREQ-1:0]   reqDataReady;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   reqDataDone;
   logic [7:0]        dataIn;
   logic              RSin;
   logic              RWin;
   logic              dataReady;
   logic              dataDone;
   logic              timeoutErr;

   int testsRun    = 0;
   int testsFailed = 0;

   bit autoReq  = 1'b0;
   bit autoDrv  = 1'b0;
   int drvDelay = 5;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] drvLog[$];
   int         grantLog[$];
   int         doneCnt0;
   int         doneCnt1;
   int         errCnt;
   int         grantViol;
   logic [1:0] prevGrant;

   lcd_bus_arbiter #(
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .int_osc      (int_osc),
      .reset        (reset),
      .en           (en),
      .req          (req),
      .reqDataIn    (reqDataIn),
      .reqRS        (reqRS),
      .reqRW        (reqRW),
      .reqDataReady (reqDataReady),
      .grant        (grant),
      .reqDataDone  (reqDataDone),
      .dataIn       (dataIn),
      .RSin         (RSin),
      .RWin         (RWin),
      .dataReady    (dataReady),
      .dataDone     (dataDone),
      .timeoutErr   (timeoutErr)
   );

   initial begin
      int_osc = 1'b0;
      forever #5 int_osc = ~int_osc;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 300000");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Requester model: presents the head of its queue and pops it on reqDataDone.
   initial begin
      forever begin
         @(negedge int_osc);
         if (autoReq) begin
            if (reqDataDone[0] && q0.size() > 0) q0.delete(0);
            if (reqDataDone[1] && q1.size() > 0) q1.delete(0);
            req[0]          = (q0.size() > 0);
            reqDataReady[0] = req[0];
            if (req[0]) begin
               reqDataIn[7:0] = q0[0][7:0];
               reqRS[0]       = q0[0][8];
            end
            req[1]          = (q1.size() > 0);
            reqDataReady[1] = req[1];
            if (req[1]) begin
               reqDataIn[15:8] = q1[0][7:0];
               reqRS[1]        = q1[0][8];
            end
         end
      end
   end

   // Driver model: logs each new byte and answers dataDone drvDelay cycles later.
   initial begin
      bit drvBusy;
      int drvCnt;
      drvBusy = 1'b0;
      drvCnt  = 0;
      forever begin
         @(negedge int_osc);
         if (autoDrv) begin
            dataDone = 1'b0;
            if (dataReady && !drvBusy) begin
               drvBusy = 1'b1;
               drvCnt  = 0;
               drvLog.push_back({RSin, dataIn});
            end else if (dataReady && drvBusy) begin
               drvCnt++;
               if (drvCnt == drvDelay) dataDone = 1'b1;
            end
            if (!dataReady) drvBusy = 1'b0;
         end
      end
   end

   // Monitor: pulse counts, grant order, one-hot and mid-burst stability.
   initial begin
      prevGrant = '0;
      forever begin
         @(negedge int_osc);
         if (reqDataDone[0]) doneCnt0++;
         if (reqDataDone[1]) doneCnt1++;
         if (timeoutErr) errCnt++;
         if (grant == 2'b11) grantViol++;
         if (prevGrant != 2'b00 && grant != 2'b00 && grant != prevGrant) grantViol++;
         if (prevGrant == 2'b00 && grant != 2'b00) grantLog.push_back(grant[1] ? 1 : 0);
         prevGrant = grant;
      end
   end

   task automatic clearLogs();
      drvLog.delete();
      grantLog.delete();
      doneCnt0  = 0;
      doneCnt1  = 0;
      errCnt    = 0;
      grantViol = 0;
   endtask

   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge int_osc);
         n++;
      end while (!(q0.size() == 0 && q1.size() == 0 && grant == 2'b00) && n < 1000);
      check(tag, 32'(n < 1000), 32'd1);
      repeat (3) @(negedge int_osc);
   endtask

   task automatic waitReady(input string tag);
      int n;
      n = 0;
      while (!dataReady && n < 20) begin
         @(negedge int_osc);
         n++;
      end
      check(tag, 32'(dataReady), 32'd1);
   endtask

   task automatic startByte0(input logic [7:0] b, input logic rw);
      req[0]          = 1'b1;
      reqDataIn[7:0]  = b;
      reqRS[0]        = 1'b0;
      reqRW[0]        = rw;
      reqDataReady[0] = 1'b1;
   endtask

   task automatic endBurst();
      req          = '0;
      reqDataReady = '0;
      reqRW        = '0;
      repeat (4) @(negedge int_osc);
   endtask

   logic [8:0] expBurst[3];
   logic [8:0] expRr[4];
   logic [8:0] gotByte;
   int         m;

   initial begin
      reset        = 1'b0;
      en           = 1'b1;
      req          = '0;
      reqDataIn    = '0;
      reqRS        = '0;
      reqRW        = '0;
      reqDataReady = '0;
      dataDone     = 1'b0;
      clearLogs();

      repeat (3) @(negedge int_osc);
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_dataReady", 32'(dataReady), 32'h0);
      check("rst_dataIn", 32'(dataIn), 32'h0);
      check("rst_reqDataDone", 32'(reqDataDone), 32'h0);
      check("rst_timeoutErr", 32'(timeoutErr), 32'h0);
      reset = 1'b1;
      @(negedge int_osc);

      // Single burst of three bytes from requester 0.
      clearLogs();
      autoReq = 1'b1;
      autoDrv = 1'b1;
      q0.push_back(9'h038);
      q0.push_back(9'h006);
      q0.push_back(9'h141);
      waitIdle("burst_wait");
      expBurst = '{9'h038, 9'h006, 9'h141};
      check("burst_count", 32'(drvLog.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         gotByte = (i < drvLog.size()) ? drvLog[i] : 9'h1ff;
         check($sformatf("burst_byte%0d", i), 32'(gotByte), 32'(expBurst[i]));
      end
      check("burst_done0", 32'(doneCnt0), 32'd3);
      check("burst_done1", 32'(doneCnt1), 32'd0);
      check("burst_noerr", 32'(errCnt), 32'd0);

      // Round-robin: both request right after reset, then both again.
      reset = 1'b0;
      @(negedge int_osc);
      reset = 1'b1;
      @(negedge int_osc);
      clearLogs();
      q0.push_back(9'h011);
      q0.push_back(9'h012);
      q1.push_back(9'h121);
      q1.push_back(9'h122);
      waitIdle("rr_wait1");
      expRr = '{9'h011, 9'h012, 9'h121, 9'h122};
      check("rr_count1", 32'(drvLog.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         gotByte = (i < drvLog.size()) ? drvLog[i] : 9'h1ff;
         check($sformatf("rr_byte%0d", i), 32'(gotByte), 32'(expRr[i]));
      end
      q0.push_back(9'h031);
      q1.push_back(9'h132);
      waitIdle("rr_wait2");
      check("rr_grants", 32'(grantLog.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rr_order%0d", i), 32'((i < grantLog.size()) ? grantLog[i] : 9), 32'(i % 2));
      end
      check("rr_grant_viol", 32'(grantViol), 32'd0);
      check("rr_done0", 32'(doneCnt0), 32'd3);
      check("rr_done1", 32'(doneCnt1), 32'd3);

      // Requester 1 drops req while its byte is outstanding.
      autoReq = 1'b0;
      @(negedge int_osc);
      clearLogs();
      req             = 2'b10;
      reqDataIn[15:8] = 8'h55;
      reqRS[1]        = 1'b1;
      reqDataReady    = 2'b10;
      waitReady("drop_ready");
      req[1] = 1'b0;
      m = 0;
      while (!reqDataDone[1] && m < 40) begin
         @(negedge int_osc);
         m++;
      end
      check("drop_done", 32'(reqDataDone), 32'h2);
      check("drop_grant_held", 32'(grant), 32'h2);
      reqDataReady = '0;
      @(negedge int_osc);
      check("drop_release", 32'(grant), 32'h0);
      check("drop_dataIn", 32'(dataIn), 32'h0);
      check("drop_byte", 32'((drvLog.size() > 0) ? drvLog[0] : 9'h1ff), 32'h155);
      endBurst();

      // Async reset in the middle of a byte, then requester 1 alone.
      autoDrv  = 1'b0;
      dataDone = 1'b0;
      startByte0(8'ha5, 1'b0);
      waitReady("arst_ready");
      #2 reset = 1'b0;
      #1;
      check("arst_dataReady", 32'(dataReady), 32'h0);
      check("arst_grant", 32'(grant), 32'h0);
      check("arst_dataIn", 32'(dataIn), 32'h0);
      req          = '0;
      reqDataReady = '0;
      @(negedge int_osc);
      reset = 1'b1;
      req   = 2'b10;
      @(negedge int_osc);
      check("arst_grant1", 32'(grant), 32'h2);
      endBurst();

      // Watchdog expiry with dataDone held low.
      clearLogs();
      startByte0(8'hc3, 1'b1);
      waitReady("wdog_ready");
      check("wdog_rw", 32'(RWin), 32'h1);
      m = 0;
      do begin
         @(negedge int_osc);
         m++;
      end while (!timeoutErr && m < 40);
      check("wdog_cycles", 32'(m), 32'd20);
      check("wdog_done", 32'(reqDataDone), 32'h1);
      check("wdog_dataReady", 32'(dataReady), 32'h0);
      reqDataReady = '0;
      endBurst();
      check("wdog_errcnt", 32'(errCnt), 32'd1);

      // dataDone arriving on the expiry cycle is a normal completion.
      clearLogs();
      startByte0(8'h3c, 1'b0);
      waitReady("wdog2_ready");
      repeat (19) @(negedge int_osc);
      dataDone = 1'b1;
      @(negedge int_osc);
      dataDone = 1'b0;
      check("wdog2_done", 32'(reqDataDone), 32'h1);
      check("wdog2_noerr", 32'(timeoutErr), 32'h0);
      reqDataReady = '0;
      endBurst();
      check("wdog2_errcnt", 32'(errCnt), 32'd0);

      // Clock enable low for 10 cycles mid-byte with an ignored dataDone pulse.
      clearLogs();
      startByte0(8'h99, 1'b0);
      waitReady("en_ready");
      repeat (5) @(negedge int_osc);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         dataDone = (i == 4);
         @(negedge int_osc);
      end
      dataDone = 1'b0;
      check("en_frozen_ready", 32'(dataReady), 32'h1);
      check("en_frozen_grant", 32'(grant), 32'h1);
      check("en_frozen_done", 32'(doneCnt0), 32'd0);
      en = 1'b1;
      m = 0;
      do begin
         @(negedge int_osc);
         m++;
      end while (!timeoutErr && m < 40);
      check("en_remaining", 32'(m), 32'd15);
      reqDataReady = '0;
      endBurst();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
Shares the single LCD byte-write driver between NREQ requester FSMs, for example the parameter/value display controller and a status/menu controller. A requester holds the bus for a whole burst of bytes. The arbiter forwards each byte to the driver using the dataReady/dataDone handshake and routes completion back to the granted requester. Arbitration is round-robin between bursts, and a watchdog releases a byte whose dataDone never returns.

Parameters:
NREQ, 2, number of requesters (2..4)
TIMEOUT, 4000, enabled cycles a byte may stay outstanding before forced completion (1..65535)

Ports:
int_osc  input  1  system clock
reset  input  1  asynchronous active-low reset
en  input  1  clock enable; all state, counters and outputs freeze when low
req  input  NREQ  requester holds the bus for the whole burst while high
reqDataIn  input  8*NREQ  byte from requester i, at bits [8i+7:8i]
reqRS  input  NREQ  register select per requester
reqRW  input  NREQ  read/write per requester
reqDataReady  input  NREQ  level: requester has a byte to send
grant  output  NREQ  one-hot current owner; all zero when bus idle
reqDataDone  output  NREQ  1-cycle pulse to owner when its byte completes
dataIn  output  8  byte to LCD driver
RSin  output  1  register select to driver
RWin  output  1  read/write to driver
dataReady  output  1  byte valid to driver
dataDone  input  1  driver finished current byte
timeoutErr  output  1  1-cycle pulse on watchdog expiry

Behaviour:
- Reset (async, low): IDLE state; all outputs 0; timeout counter 0; lastGrant = NREQ-1, so requester 0 has first priority.
- All outputs are registered. When en = 0, nothing changes and dataDone is ignored.
- IDLE:
  - If any req bit is high, pick the first requester after lastGrant (wrapping); grant goes one-hot on the next cycle; go to GRANT.
  - If no req bit is high, stay in IDLE.
- GRANT (owner g):
  - dataReady = 0.
  - If reqDataReady[g] = 1: latch reqDataIn/reqRS/reqRW of g into dataIn/RSin/RWin, set dataReady = 1 (visible next cycle), clear the counter, go to BUSY.
  - Else if req[g] = 0: go to RELEASE.
  - reqDataReady[g] takes priority over a req[g] drop in the same cycle.
- BUSY:
  - dataIn/RSin/RWin/dataReady are held stable regardless of requester input changes.
  - The counter increments every enabled cycle.
  - dataDone = 1: dataReady = 0 and reqDataDone[g] pulses on the next cycle; go to GRANT.
  - Counter reaches TIMEOUT-1 with dataDone = 0: same as completion, plus a timeoutErr pulse.
  - dataDone on the expiry cycle counts as normal completion; no error.
- Completion always passes through GRANT, giving at least one dataReady-low cycle between bytes. A requester that keeps reqDataReady high across the reqDataDone pulse sends its next byte immediately.
- req[g] dropping during BUSY is ignored until the byte completes; an LCD write is never aborted.
- RELEASE (1 cycle): grant = 0, all driver outputs = 0, lastGrant = g; go to IDLE.
- dataDone outside BUSY is ignored. reqDataDone is only ever driven to the current owner. Non-owner inputs never reach the driver. Unowned-bus driver outputs are 0.
- Worst-case latency from req to grant: one cycle from IDLE, plus the current owner's remaining burst.

Test Plan:
- Reset: pull reset low mid-BUSY with dataReady = 1 -> all outputs 0 immediately with no clock edge. After release, req[1] alone -> grant = 2'b10 one cycle later.
- Single burst: req[0] sends 0x38 (RS = 0), 0x06 (RS = 0), 0x41 (RS = 1); driver returns dataDone 5 cycles after each dataReady -> driver sees exactly these 3 bytes with matching RS, three reqDataDone[0] pulses, and a dataReady low gap of at least 1 cycle between bytes.
- Round-robin: req = 2'b11 right after reset -> requester 0 served first, then 1. Both re-request after that -> requester 0 again. grant is never two-hot and never changes mid-burst.
- Drop during BUSY: req[1] falls while its byte is outstanding -> byte completes, reqDataDone[1] pulses, then RELEASE and grant = 0.
- Watchdog: TIMEOUT = 20, dataDone held 0 -> after 20 BUSY cycles, timeoutErr and reqDataDone pulse and dataReady falls. Repeat with dataDone on cycle 20 -> no timeoutErr.
- Enable: en = 0 for 10 cycles during BUSY with a dataDone pulse inside the window -> outputs and counter frozen, dataDone ignored, byte still outstanding after en returns.
